exhaustive_sweep_capture: RTL and testbench

//  Synthesizable stimulus/response stage wrapped around a benchmark DUT.
//  - Upstream side: drives every input pattern 0..2**N_IN-1 to the DUT in order.
//  - Downstream side: samples the DUT response for each pattern after a settle window.
//  - Emits {pattern, response} records over valid/ready to the logger/compare stage.

---
 rtl/sweep_pkg.sv | 14 +
 rtl/sweep_misr.sv | 36 +++
 rtl/exhaustive_sweep_capture.sv | 116 +++++++++++
 tb/tb_exhaustive_sweep_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared FSM state encoding and default MISR polynomial for exhaustive_sweep_capture.
package sweep_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SAMPLE = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4
   } sweep_state_e;

   localparam logic [15:0] POLY = 16'h1021;

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register folding each accepted {pattern, response} record.
module sweep_misr
   import sweep_pkg::*;
#(
   parameter int SIG_W = 16,
   parameter int DIN_W = 4
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [DIN_W-1:0] din,
   output logic [SIG_W-1:0] sig
);

   localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

   // Shift left, feed back the polynomial on a dropped MSB, then fold in the record.
   function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                  input logic [DIN_W-1:0] d);
      logic [SIG_W-1:0] fb;
      fb = s[SIG_W-1] ? POLY_W : '0;
      return {s[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(d);
   endfunction

   always_ff @(posedge CK) begin
      if (reset) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= misr_next(sig, din);
      end
   end

endmodule

// File: rtl/exhaustive_sweep_capture.sv
// Drives every N_IN-bit pattern to a benchmark DUT, samples its response after a settle
// window and emits {pattern, response} records. Optional signature via SWEEP_MISR_EN.
module exhaustive_sweep_capture
   import sweep_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int OUT_W  = 1,
   parameter int SETTLE = 1,
   parameter int SIG_W  = 16
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [N_IN-1:0]  pat,
   input  logic [OUT_W-1:0] dut_out,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [N_IN-1:0]  rec_pat,
   output logic [OUT_W-1:0] rec_resp,
   output logic [SIG_W-1:0] sig
);

   localparam int CNT_W = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  PAT_LAST    = '1;

   if (SETTLE < 1) begin : g_settle_chk
      $error("exhaustive_sweep_capture: SETTLE must be at least 1");
   end

   sweep_state_e     state;
   logic [CNT_W-1:0] settle_cnt;

   always_ff @(posedge CK) begin
      if (reset) begin
         state      <= IDLE;
         pat        <= '0;
         settle_cnt <= '0;
         rec_pat    <= '0;
         rec_resp   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= DRIVE;
                  pat        <= '0;
                  settle_cnt <= '0;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= SAMPLE;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            SAMPLE: begin
               rec_pat  <= pat;
               rec_resp <= dut_out;
               state    <= EMIT;
            end
            EMIT: begin
               // The all-ones pattern ends the sweep, so pat never wraps within one.
               if (rec_ready) begin
                  if (pat == PAT_LAST) begin
                     state <= DONE;
                  end else begin
                     pat   <= pat + N_IN'(1);
                     state <= DRIVE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign rec_valid = (state == EMIT);

`ifdef SWEEP_MISR_EN
   if (SIG_W < N_IN + OUT_W) begin : g_sig_chk
      $error("exhaustive_sweep_capture: SIG_W must cover N_IN+OUT_W");
   end

   logic misr_clr;
   logic misr_en;

   assign misr_clr = (state == IDLE) && start;
   assign misr_en  = rec_valid && rec_ready;

   sweep_misr #(
      .SIG_W (SIG_W),
      .DIN_W (N_IN + OUT_W)
   ) u_misr (
      .CK    (CK),
      .reset (reset),
      .clr   (misr_clr),
      .en    (misr_en),
      .din   ({rec_pat, rec_resp}),
      .sig   (sig)
   );
`else
   assign sig = '0;
`endif

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Scoreboard bench for exhaustive_sweep_capture: two instances (SETTLE=1 and SETTLE=4).
module tb_exhaustive_sweep_capture;

   localparam int N_IN  = 3;
   localparam int OUT_W = 1;
   localparam int SIG_W = 16;
   localparam int NPAT  = 1 << N_IN;

   logic CK = 1'b0;
   always #5 CK = ~CK;

   logic reset;
   logic start_a, busy_a, done_a, rec_valid_a, ready_a;
   logic [N_IN-1:0]  pat_a, rec_pat_a;
   logic [OUT_W-1:0] dut_out_a, rec_resp_a;
   logic [SIG_W-1:0] sig_a;
   logic start_b, busy_b, done_b, rec_valid_b, ready_b;
   logic [N_IN-1:0]  pat_b, rec_pat_b;
   logic [OUT_W-1:0] dut_out_b, rec_resp_b;
   logic [SIG_W-1:0] sig_b;

   int errors = 0;
   int checks = 0;
   int edges  = 0;
   always @(posedge CK) edges <= edges + 1;

   // Response source for instance A: 0 parity, 1 constant zero, 2 random table.
   int mode = 0;
   logic [OUT_W-1:0] resp_tab [NPAT];
   assign dut_out_a = (mode == 0) ? OUT_W'(^pat_a) :
                      (mode == 1) ? '0 : resp_tab[pat_a];

   logic d1, d2, d3;
   always @(posedge CK) begin
      d1 <= pat_b[0];
      d2 <= d1;
      d3 <= d2;
   end
   assign dut_out_b = d3;

   exhaustive_sweep_capture #(.N_IN(N_IN), .OUT_W(OUT_W), .SETTLE(1), .SIG_W(SIG_W)) u_a (
      .CK(CK), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .pat(pat_a),
      .dut_out(dut_out_a), .rec_valid(rec_valid_a), .rec_ready(ready_a),
      .rec_pat(rec_pat_a), .rec_resp(rec_resp_a), .sig(sig_a));

   exhaustive_sweep_capture #(.N_IN(N_IN), .OUT_W(OUT_W), .SETTLE(4), .SIG_W(SIG_W)) u_b (
      .CK(CK), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .pat(pat_b),
      .dut_out(dut_out_b), .rec_valid(rec_valid_b), .rec_ready(ready_b),
      .rec_pat(rec_pat_b), .rec_resp(rec_resp_b), .sig(sig_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [SIG_W-1:0] misr_fold(input logic [SIG_W-1:0] s,
                                                  input logic [N_IN+OUT_W-1:0] d);
      logic [SIG_W-1:0] r;
      r = {s[SIG_W-2:0], 1'b0};
      if (s[SIG_W-1]) r = r ^ 16'h1021;
      return r ^ SIG_W'(d);
   endfunction

   function automatic logic [OUT_W-1:0] ref_resp(input int p);
      logic [N_IN-1:0] pp;
      pp = p[N_IN-1:0];
      if (mode == 0) return OUT_W'($countones(pp) % 2);
      if (mode == 1) return '0;
      return resp_tab[p];
   endfunction

   // Scoreboards: expected {pattern, response} records in acceptance order.
   logic [N_IN+OUT_W-1:0] q_a [$];
   logic [N_IN+OUT_W-1:0] q_b [$];
   logic [N_IN+OUT_W-1:0] e_a, e_b;
   logic [SIG_W-1:0] sig_model = '0;
   int stalls_a = 0;
   int done_cnt_a = 0;

   always @(negedge CK) begin
      if (!reset && rec_valid_a && ready_a) begin
         if (q_a.size() == 0) begin
            chk("rec_a_unexpected", {rec_pat_a, rec_resp_a}, 32'hFFFF);
         end else begin
            e_a = q_a.pop_front();
            chk("rec_a", {rec_pat_a, rec_resp_a}, e_a);
            sig_model = misr_fold(sig_model, e_a);
         end
      end
      if (!reset && rec_valid_a && !ready_a) stalls_a++;
      if (done_a) done_cnt_a++;
   end

   always @(negedge CK) begin
      if (!reset && rec_valid_b && ready_b) begin
         if (q_b.size() == 0) begin
            chk("rec_b_unexpected", {rec_pat_b, rec_resp_b}, 32'hFFFF);
         end else begin
            e_b = q_b.pop_front();
            chk("rec_b", {rec_pat_b, rec_resp_b}, e_b);
         end
      end
   end

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic push_sweep_a();
      for (int p = 0; p < NPAT; p++) q_a.push_back({N_IN'(p), ref_resp(p)});
   endtask

   task automatic start_a_sweep(output int e0);
      tick();
      start_a = 1'b1;
      tick();
      e0 = edges;
      start_a = 1'b0;
   endtask

   // Returns the edge count at the negedge where done is seen; -1 on timeout.
   task automatic wait_done(input bit which_b, input int maxc, input bit rnd, output int de);
      de = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge CK);
         if ((which_b ? done_b : done_a) === 1'b1) begin
            de = edges;
            break;
         end
         @(posedge CK);
         #1;
         if (rnd) ready_a = 1'($urandom_range(0, 1));
      end
      if (de < 0) chk(which_b ? "done_b_timeout" : "done_a_timeout", 32'h0, 32'h1);
      tick();
      ready_a = 1'b1;
   endtask

   task automatic check_sig(input string name, input logic [SIG_W-1:0] model);
`ifdef SWEEP_MISR_EN
      chk(name, sig_a, model);
`else
      chk(name, sig_a, 32'h0);
`endif
   endtask

   int e0, de, dcnt, ok;
   logic [SIG_W-1:0] evens;

   initial begin
      reset = 1'b1; start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
      for (int p = 0; p < NPAT; p++) resp_tab[p] = '0;
      repeat (3) tick();
      @(negedge CK);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pat", pat_a, 0);
      chk("rst_valid", rec_valid_a, 0);
      chk("rst_rec", {rec_pat_a, rec_resp_a}, 0);
      chk("rst_sig", sig_a, 0);
      tick();
      reset = 1'b0;

      // Parity DUT, free-flowing downstream.
      mode = 0; push_sweep_a(); sig_model = '0; dcnt = done_cnt_a;
      start_a_sweep(e0);
      @(negedge CK);
      chk("t1_busy", busy_a, 1);
      wait_done(0, 100, 0, de);
      chk("t1_done_cycle", de - e0, 24);
      check_sig("t1_sig", sig_model);
      repeat (3) tick();
      chk("t1_done_pulses", done_cnt_a - dcnt, 1);
      chk("t1_pat_hold", pat_a, 7);
      chk("t1_idle", busy_a, 0);
      chk("t1_q_empty", q_a.size(), 0);

      // Random responses, 5-cycle stall on record 2.
      mode = 2;
      for (int p = 0; p < NPAT; p++) resp_tab[p] = OUT_W'($urandom_range(0, 1));
      push_sweep_a(); sig_model = '0; stalls_a = 0;
      start_a_sweep(e0);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (pat_a == 2) begin ok = 1; break; end
         tick();
      end
      chk("t2_reach_pat2", ok, 1);
      ready_a = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (rec_valid_a) begin ok = 1; break; end
         tick();
      end
      chk("t2_emit2", ok, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge CK);
         chk("t2_stall_state", {rec_valid_a, rec_pat_a, pat_a}, {1'b1, 3'd2, 3'd2});
         tick();
      end
      ready_a = 1'b1;
      wait_done(0, 100, 0, de);
      chk("t2_done_cycle", de - e0, 29);
      chk("t2_stalls", stalls_a, 5);
      check_sig("t2_sig", sig_model);

      // Random responses with random backpressure.
      for (int p = 0; p < NPAT; p++) resp_tab[p] = OUT_W'($urandom_range(0, 1));
      push_sweep_a(); sig_model = '0; stalls_a = 0;
      start_a_sweep(e0);
      ready_a = 1'($urandom_range(0, 1));
      wait_done(0, 400, 1, de);
      chk("t2r_done_cycle", de - e0, 24 + stalls_a);
      chk("t2r_q_empty", q_a.size(), 0);
      check_sig("t2r_sig", sig_model);

      // Settle window of 4 with a 3-cycle-latency DUT.
      for (int p = 0; p < NPAT; p++) q_b.push_back({N_IN'(p), OUT_W'(p % 2)});
      tick(); start_b = 1'b1; tick(); e0 = edges; start_b = 1'b0;
      wait_done(1, 200, 0, de);
      chk("t3_done_cycle", de - e0, 48);
      chk("t3_q_empty", q_b.size(), 0);

      // Reset in the middle of a sweep.
      mode = 0; push_sweep_a(); sig_model = '0; dcnt = done_cnt_a;
      start_a_sweep(e0);
      while (edges < e0 + 9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q_a.delete();
      sig_model = '0;
      @(negedge CK);
      chk("t4_busy", busy_a, 0);
      chk("t4_valid", rec_valid_a, 0);
      chk("t4_pat", pat_a, 0);
      chk("t4_sig", sig_a, 0);
      repeat (20) tick();
      chk("t4_no_done", done_cnt_a - dcnt, 0);
      push_sweep_a();
      start_a_sweep(e0);
      wait_done(0, 100, 0, de);
      chk("t4_rerun_done", de - e0, 24);
      chk("t4_q_empty", q_a.size(), 0);

      // start held high through a sweep and its DONE cycle.
      push_sweep_a(); push_sweep_a(); sig_model = '0; dcnt = done_cnt_a;
      tick(); start_a = 1'b1; tick(); e0 = edges;
      wait_done(0, 100, 0, de);
      chk("t5_first_done", de - e0, 24);
      check_sig("t5_sig1", sig_model);
      @(negedge CK);
      chk("t5_idle_gap", busy_a, 0);
      sig_model = '0;
      tick();
      @(negedge CK);
      chk("t5_restart", {busy_a, pat_a}, {1'b1, 3'd0});
      tick();
      start_a = 1'b0;
      wait_done(0, 100, 0, de);
      chk("t5_second_done", de - e0, 50);
      repeat (3) tick();
      chk("t5_done_pulses", done_cnt_a - dcnt, 2);
      chk("t5_q_empty", q_a.size(), 0);

      // Constant-zero DUT: signature over records 0,2,...,14.
      mode = 1; push_sweep_a(); sig_model = '0;
      start_a_sweep(e0);
      wait_done(0, 100, 0, de);
      evens = '0;
      for (int k = 0; k < NPAT; k++) evens = misr_fold(evens, 4'(2 * k));
      check_sig("t6_sig_model", sig_model);
      check_sig("t6_sig_evens", evens);
      repeat (4) tick();
      check_sig("t6_sig_hold", evens);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
